// File: rtl/uart_packet_tx.sv
// uart_packet_tx: FIFO-buffered UART transmitter (8N2, LSB first) that closes each packet with an idle gap.
// Define UART_PKT_TX_PARITY_EN to insert an even-parity bit, giving 8E2 frames.
module uart_packet_tx #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          TxD,
  output logic                          busy,
  output logic                          pkt_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV     = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(DIV);
  localparam int unsigned BIT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int unsigned BW      = $clog2(BIT_MAX);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_packet_tx: bit period DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_packet_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (GAP_BITS < 1) begin : g_bad_gap
    $error("uart_packet_tx: GAP_BITS must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PKT_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  // FIFO entries hold {last, data}
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [8:0]    head;
  logic          push;
  logic          pop;
  logic          nonempty;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [7:0]    shift;
  logic          last_flag;
  logic          done_pre;
  logic          period_end;
  logic          stop_done;
  logic          line_bit;
`ifdef UART_PKT_TX_PARITY_EN
  logic          parity;
`endif

  assign in_ready   = (count != FULL_COUNT);
  assign nonempty   = (count != '0);
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  assign period_end = (cnt == CW'(DIV - 1));
  assign stop_done  = (state == STOP) && period_end && (bits == BW'(1));
  // Pop from IDLE, or at the end of stop bits when the packet is still open (back-to-back)
  assign pop        = nonempty && ((state == IDLE) || (stop_done && !last_flag));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift[0];
`ifdef UART_PKT_TX_PARITY_EN
      PARITY:  line_bit = parity;
`endif
      default: line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line trails the state by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      shift     <= '0;
      last_flag <= 1'b0;
      done_pre  <= 1'b0;
      TxD       <= 1'b1;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
`ifdef UART_PKT_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      TxD      <= line_bit;
      busy     <= (state != IDLE) || done_pre;
      pkt_done <= done_pre;
      done_pre <= 1'b0;
      cnt      <= period_end ? '0 : cnt + 1'b1;

      if (pop) begin
        shift     <= head[7:0];
        last_flag <= head[8];
`ifdef UART_PKT_TX_PARITY_EN
        parity    <= ^head[7:0];
`endif
      end

      case (state)
        IDLE: begin
          cnt  <= '0;
          bits <= '0;
          if (nonempty) state <= START;
        end
        START: begin
          if (period_end) begin
            bits  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (period_end) begin
            shift <= {1'b0, shift[7:1]};
            if (bits == BW'(7)) begin
              bits  <= '0;
`ifdef UART_PKT_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bits <= bits + 1'b1;
            end
          end
        end
`ifdef UART_PKT_TX_PARITY_EN
        PARITY: begin
          if (period_end) begin
            bits  <= '0;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (period_end) begin
            if (bits == BW'(1)) begin
              bits <= '0;
              if (last_flag)     state <= GAP;
              else if (nonempty) state <= START;
              else               state <= IDLE;
            end else begin
              bits <= bits + 1'b1;
            end
          end
        end
        GAP: begin
          if (period_end) begin
            if (bits == BW'(GAP_BITS - 1)) begin
              bits     <= '0;
              done_pre <= 1'b1;
              state    <= IDLE;
            end else begin
              bits <= bits + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Scoreboard bench for uart_packet_tx: a line monitor decodes frames and checks them against queued expectations.
module tb_uart_packet_tx;

  localparam int unsigned DIV = 8;
  localparam int unsigned GAP = 4;
`ifdef UART_PKT_TX_PARITY_EN
  localparam int unsigned FB = 12;
`else
  localparam int unsigned FB = 11;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       TxD;
  logic       busy;
  logic       pkt_done;
  logic [2:0] fifo_count;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;
  int unsigned dones = 0;
  logic        rst_seen = 1'b0;

  logic [8:0]  exp_q[$];
  int unsigned done_q[$];
  int unsigned starts[$];

  uart_packet_tx #(
    .CLK_FREQ(800),
    .BAUD(100),
    .FIFO_DEPTH(4),
    .GAP_BITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .TxD(TxD),
    .busy(busy),
    .pkt_done(pkt_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns k, the posedge number at which the byte is accepted
  task automatic push(input logic [7:0] d, input logic l, output int unsigned k);
    int unsigned w = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    k = cyc + 1;
    if (w >= 1000) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: in_ready stayed %b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({l, d});
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_frame(input int n);
    int unsigned w = 0;
    while (starts.size() <= n && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("frame_started", starts.size() > n, 1);
  endtask

  function automatic int unsigned start_of(input int n);
    return (starts.size() > n) ? starts[n] : 0;
  endfunction

  task automatic wait_idle();
    int unsigned w = 0;
    while (!(exp_q.size() == 0 && done_q.size() == 0 && busy === 1'b0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", w < 3000, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0]  b;
    logic        sbit;
    logic        s1;
    logic        s2;
    logic        gap_ok;
    logic [8:0]  e;
    int unsigned t0;
`ifdef UART_PKT_TX_PARITY_EN
    logic        pbit;
`endif
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TxD === 1'b0) begin
        t0 = cyc;
        rst_seen = 1'b0;
        starts.push_back(t0);
        repeat (DIV / 2) @(negedge clk);
        sbit = TxD;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = TxD;
        end
`ifdef UART_PKT_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        pbit = TxD;
`endif
        repeat (DIV) @(negedge clk);
        s1 = TxD;
        repeat (DIV) @(negedge clk);
        s2 = TxD;
        if (!rst_seen) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_frame: got byte %02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", b, e[7:0]);
            check("start_bit", sbit, 0);
            check("stop_bits", {s1, s2}, 2'b11);
`ifdef UART_PKT_TX_PARITY_EN
            check("parity_bit", pbit, ^e[7:0]);
`endif
            if (e[8]) begin
              done_q.push_back(t0 + FB * DIV + GAP * DIV);
              gap_ok = 1'b1;
              while (cyc < t0 + FB * DIV + GAP * DIV) begin
                @(negedge clk);
                gap_ok = gap_ok & TxD;
              end
              check("gap_idle", gap_ok, 1);
            end
          end
        end
      end
    end
  end

  initial begin : done_watch
    int unsigned want;
    forever begin
      @(negedge clk);
      if (pkt_done === 1'b1) begin
        dones++;
        if (done_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_pkt_done: pulse at cycle %0d, expected none", cyc);
        end else begin
          want = done_q.pop_front();
          check("pkt_done_cycle", cyc, want);
        end
        check("busy_during_done", busy, 1);
        @(negedge clk);
        check("pkt_done_width", pkt_done, 0);
        if (exp_q.size() == 0) check("busy_after_done", busy, 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned k;
    int unsigned k2;
    int          n;
    int unsigned d0;

    repeat (3) @(negedge clk);
    check("reset_txd", TxD, 1);
    check("reset_busy", busy, 0);
    check("reset_pkt_done", pkt_done, 0);
    check("reset_fifo_count", fifo_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    // single-byte packet: latency, timing and gap
    n  = starts.size();
    d0 = dones;
    push(8'h55, 1'b1, k);
    wait_frame(n);
    check("t1_start_latency", start_of(n), k + 2);
    repeat (20) @(negedge clk);
    check("t1_busy_mid_frame", busy, 1);
    wait_idle();
    check("t1_done_count", dones - d0, 1);

    // two-byte packet: back-to-back frames, single pkt_done
    n  = starts.size();
    d0 = dones;
    push(8'hA3, 1'b0, k);
    push(8'h0F, 1'b1, k2);
    wait_idle();
    check("t2_frame_count", starts.size() - n, 2);
    check("t2_b2b_spacing", start_of(n + 1) - start_of(n), FB * DIV);
    check("t2_done_count", dones - d0, 1);

    // fill the FIFO while the first byte is on the line
    n  = starts.size();
    d0 = dones;
    push(8'h10, 1'b0, k);
    push(8'h21, 1'b0, k);
    push(8'h32, 1'b0, k);
    push(8'h43, 1'b0, k);
    push(8'h54, 1'b1, k);
    check("t3_fifo_full_count", fifo_count, 4);
    check("t3_in_ready_full", in_ready, 0);
    wait_idle();
    check("t3_frame_count", starts.size() - n, 5);
    check("t3_done_count", dones - d0, 1);

    // open packet: no gap, no pkt_done, then continuation byte closes it
    n  = starts.size();
    d0 = dones;
    push(8'h01, 1'b0, k);
    wait_frame(n);
    while (cyc < start_of(n) + 100) @(negedge clk);
    check("t4_busy_open_packet", busy, 0);
    check("t4_txd_idle", TxD, 1);
    check("t4_no_done", dones - d0, 0);
    push(8'h02, 1'b1, k);
    wait_idle();
    check("t4_done_count", dones - d0, 1);

    // reset during bit 3 of 0x00 with a second byte still queued
    push(8'h00, 1'b1, k);
    push(8'h11, 1'b1, k2);
    while (cyc < k + 2 + 4 * DIV + 3) @(negedge clk);
    check("t5_txd_bit3", TxD, 0);
    check("t5_fifo_before_reset", fifo_count, 1);
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    check("t5_txd_in_reset", TxD, 1);
    check("t5_fifo_in_reset", fifo_count, 0);
    check("t5_busy_in_reset", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready_after", in_ready, 1);
    check("t5_txd_after", TxD, 1);
    repeat (100) @(negedge clk);
    n  = starts.size();
    d0 = dones;
    push(8'h5A, 1'b1, k);
    wait_frame(n);
    check("t5_restart_latency", start_of(n), k + 2);
    wait_idle();
    check("t5_done_count", dones - d0, 1);

`ifdef UART_PKT_TX_PARITY_EN
    d0 = dones;
    push(8'h07, 1'b1, k);
    push(8'h03, 1'b1, k2);
    wait_idle();
    check("t6_done_count", dones - d0, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
